// File: rtl/rvv_pkg.sv
// Shared RVV definitions for the vector configuration unit.
// Holds the vtype encoding (vtype_t with its vew_e / vlmul_e fields), the
// vcfg FSM state enum, the illegal-vtype constant and a VLMAX helper.
package rvv_pkg;

    typedef enum logic [2:0] {
        EW8    = 3'd0,
        EW16   = 3'd1,
        EW32   = 3'd2,
        EW64   = 3'd3,
        EW128  = 3'd4,
        EW256  = 3'd5,
        EW512  = 3'd6,
        EW1024 = 3'd7
    } vew_e;

    typedef enum logic [2:0] {
        LMUL_1    = 3'd0,
        LMUL_2    = 3'd1,
        LMUL_4    = 3'd2,
        LMUL_8    = 3'd3,
        LMUL_RSVD = 3'd4,
        LMUL_1_8  = 3'd5,
        LMUL_1_4  = 3'd6,
        LMUL_1_2  = 3'd7
    } vlmul_e;

    // Bit order matches the architectural vtype low byte with vill on top.
    typedef struct packed {
        logic   vill;
        logic   vma;
        logic   vta;
        vew_e   vsew;
        vlmul_e vlmul;
    } vtype_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        UPDATE = 2'd2,
        RESP   = 2'd3
    } vcfg_state_e;

    localparam vtype_t VTYPE_ILLEGAL = '{vill: 1'b1, vma: 1'b0, vta: 1'b0,
                                         vsew: EW8, vlmul: LMUL_1};

    // VLMAX = (VLEN / SEW) * LMUL; SEW = 8 << vsew, so VLEN / SEW is a shift.
    function automatic int unsigned vlmax(input int unsigned vlen,
                                          input vew_e vsew,
                                          input vlmul_e vlmul);
        int unsigned base;
        base = vlen >> (32'd3 + 32'(vsew));
        case (vlmul)
            LMUL_1:   return base;
            LMUL_2:   return base << 1;
            LMUL_4:   return base << 2;
            LMUL_8:   return base << 3;
            LMUL_1_2: return base >> 1;
            LMUL_1_4: return base >> 2;
            LMUL_1_8: return base >> 3;
            default:  return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/vcfg_outstanding_cnt.sv
// Counts vector instructions in flight.
// Ports: clk_i/rst_i (sync active-high), inc_i (accepted issue), dec_i
// (retire), cnt_o (current count), full_o (count reached MaxOutstanding).
module vcfg_outstanding_cnt #(
    parameter  int unsigned MaxOutstanding = 8,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && !dec_i) begin
            cnt_o <= cnt_o + CntW'(1);
        end else if (dec_i && !inc_i && (cnt_o != '0)) begin
            // A retire with nothing in flight is dropped rather than wrapping.
            cnt_o <= cnt_o - CntW'(1);
        end
    end

    assign full_o = (cnt_o >= CntW'(MaxOutstanding));

endmodule

// File: rtl/vcfg_unit.sv
// Vector configuration unit: executes vsetvli / vsetivli / vsetvl once all
// in-flight vector instructions have retired, then returns the new vl.
// Ports: clk_i, rst_i (sync active-high); req_* request handshake with the
// instruction and scalar operands; resp_* response carrying the new vl;
// issue_i / retire_i / issue_ready_o in-flight tracking; vl_o, vtype_o,
// vstart_o architectural CSR values.
module vcfg_unit
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN           = 4096,
    parameter int unsigned ELEN           = 64,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_instr_i,
    input  logic [ELEN-1:0]          req_rs1_i,
    input  logic [ELEN-1:0]          req_rs2_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [ELEN-1:0]          resp_rd_o,
    input  logic                     issue_i,
    input  logic                     retire_i,
    output logic                     issue_ready_o,
    output logic [$clog2(VLEN):0]    vl_o,
    output vtype_t                   vtype_o,
    output logic [$clog2(VLEN)-1:0]  vstart_o
);

    localparam int unsigned VlW  = $clog2(VLEN) + 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    vcfg_state_e     state_q;
    logic [31:0]     instr_q;
    logic [ELEN-1:0] rs1_q;
    logic [ELEN-1:0] rs2_q;

    logic [CntW-1:0] cnt;
    logic            cnt_full;

    logic [7:0]      vt_bits;
    logic            enc_ok;
    logic            hi_bits_set;
    logic            is_ivli;
    vew_e            vsew;
    vlmul_e          vlmul;
    int unsigned     sew_bits;
    logic            frac_ill;
    logic            ill;
    logic [ELEN-1:0] vlmax_e;
    logic [ELEN-1:0] avl;
    logic [VlW-1:0]  new_vl;
    vtype_t          new_vtype;

    assign req_ready_o   = (state_q == IDLE);
    assign issue_ready_o = !cnt_full && ((state_q == IDLE) || (state_q == RESP));

    vcfg_outstanding_cnt #(
        .MaxOutstanding (MaxOutstanding)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (issue_i && issue_ready_o),
        .dec_i  (retire_i),
        .cnt_o  (cnt),
        .full_o (cnt_full)
    );

    // Decode of the latched request into the candidate vtype and vl.
    always_comb begin
        vt_bits     = '0;
        hi_bits_set = 1'b0;
        enc_ok      = (instr_q[6:0] == 7'h57) && (instr_q[14:12] == 3'b111);
        is_ivli     = (instr_q[31:30] == 2'b11);
        if (!instr_q[31]) begin
            vt_bits = instr_q[27:20];
        end else if (is_ivli) begin
            vt_bits = instr_q[27:20];
        end else if (instr_q[31:25] == 7'b1000000) begin
            vt_bits     = rs2_q[7:0];
            hi_bits_set = |rs2_q[ELEN-1:8];
        end else begin
            enc_ok = 1'b0;
        end

        vsew     = vew_e'(vt_bits[5:3]);
        vlmul    = vlmul_e'(vt_bits[2:0]);
        sew_bits = 32'd8 << vt_bits[5:3];

        case (vlmul)
            LMUL_1_2: frac_ill = (sew_bits > ELEN / 2);
            LMUL_1_4: frac_ill = (sew_bits > ELEN / 4);
            LMUL_1_8: frac_ill = (sew_bits > ELEN / 8);
            default:  frac_ill = 1'b0;
        endcase

        ill = !enc_ok || hi_bits_set || (vlmul == LMUL_RSVD) ||
              (sew_bits > ELEN) || frac_ill;

        vlmax_e = ELEN'(vlmax(VLEN, vsew, vlmul));

        if (is_ivli) begin
            avl = ELEN'(instr_q[19:15]);
        end else if (instr_q[19:15] != 5'd0) begin
            avl = rs1_q;
        end else if (instr_q[11:7] != 5'd0) begin
            avl = vlmax_e;
        end else begin
            // rs1=x0, rd=x0: keep the current vl, clamped below.
            avl = ELEN'(vl_o);
        end

        // Full-width compare so a huge AVL cannot alias to a small vl.
        if (ill) begin
            new_vl    = '0;
            new_vtype = VTYPE_ILLEGAL;
        end else begin
            new_vl    = (avl < vlmax_e) ? avl[VlW-1:0] : vlmax_e[VlW-1:0];
            new_vtype = vtype_t'({1'b0, vt_bits});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            vl_o         <= '0;
            vtype_o      <= VTYPE_ILLEGAL;
            vstart_o     <= '0;
            resp_valid_o <= 1'b0;
            resp_rd_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        instr_q <= req_instr_i;
                        rs1_q   <= req_rs1_i;
                        rs2_q   <= req_rs2_i;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    vl_o         <= new_vl;
                    vtype_o      <= new_vtype;
                    vstart_o     <= '0;
                    resp_valid_o <= 1'b1;
                    resp_rd_o    <= ELEN'(new_vl);
                    state_q      <= RESP;
                end
                default: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vcfg_unit.sv
`timescale 1ns/1ps
module tb_vcfg_unit;
    import rvv_pkg::*;

    localparam int unsigned VLEN = 4096;
    localparam int unsigned ELEN = 64;
    localparam int unsigned MAXO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rd;
    logic        issue = 1'b0;
    logic        retire = 1'b0;
    logic        issue_ready;
    logic [12:0] vl;
    vtype_t      vtype;
    logic [11:0] vstart;

    vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_instr_i(req_instr),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rd_o(resp_rd),
        .issue_i(issue), .retire_i(retire), .issue_ready_o(issue_ready),
        .vl_o(vl), .vtype_o(vtype), .vstart_o(vstart)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] vl;
        logic [8:0]  vt;
        int          exp_cyc;
    } exp_t;
    exp_t sb_q[$];

    logic [63:0] model_vl = '0;
    bit rr_rand = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp_v, exp_v, cyc);
        end
    endtask

    // Reference model: vtype legality and vl from the architectural rules.
    function automatic void model(input logic [31:0] ins, input logic [63:0] rs1,
                                  input logic [63:0] rs2,
                                  output logic [63:0] evl, output logic [8:0] evt);
        int lnum[8] = '{1, 2, 4, 8, 0, 1, 1, 1};
        int lden[8] = '{1, 1, 1, 1, 0, 8, 4, 2};
        logic [7:0] vt;
        bit ill;
        bit ivli;
        longint unsigned avl, vmax, sew;
        int lm;
        ill  = 0;
        vt   = '0;
        ivli = (ins[31:30] == 2'b11);
        if (ins[6:0] != 7'h57 || ins[14:12] != 3'b111) ill = 1;
        if (!ins[31]) vt = ins[27:20];
        else if (ivli) vt = ins[27:20];
        else if (ins[31:25] == 7'b1000000) begin
            vt = rs2[7:0];
            if ((rs2 >> 8) != 0) ill = 1;
        end else ill = 1;
        lm   = int'(vt[2:0]);
        sew  = 8 * (longint'(1) << vt[5:3]);
        vmax = 0;
        if (lm == 4) ill = 1;
        if (sew > ELEN) ill = 1;
        if (!ill && sew * longint'(lden[lm]) > longint'(ELEN) * longint'(lnum[lm])) ill = 1;
        if (!ill) vmax = (longint'(VLEN) * longint'(lnum[lm])) / (sew * longint'(lden[lm]));
        if (ivli) avl = 64'(ins[19:15]);
        else if (ins[19:15] != 0) avl = rs1;
        else if (ins[11:7] != 0) avl = vmax;
        else avl = model_vl;
        evl = ill ? 64'd0 : ((avl < vmax) ? avl : vmax);
        evt = ill ? 9'h100 : {1'b0, vt};
        model_vl = evl;
    endfunction

    function automatic logic [31:0] mk_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [10:0] z);
        return {1'b0, z, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] mk_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                                input logic [9:0] z);
        return {2'b11, z, uimm, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] mk_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2f);
        return {7'b1000000, rs2f, rs1, 3'b111, rd, 7'h57};
    endfunction

    // Response monitor / scoreboard.
    bit seen = 0;
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rd=%0d with no request pending at cycle %0d",
                         resp_rd, cyc);
            end else begin
                check("resp_rd", resp_rd, sb_q[0].vl);
                if (!seen) begin
                    seen = 1;
                    if (sb_q[0].exp_cyc >= 0) check("resp_latency", 64'(cyc), 64'(sb_q[0].exp_cyc));
                end
                if (resp_ready) begin
                    check("vl_o", 64'(vl), sb_q[0].vl);
                    check("vtype_o", 64'(vtype), 64'(sb_q[0].vt));
                    check("vstart_o", 64'(vstart), 64'd0);
                    void'(sb_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rr_rand) begin
            #1 resp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_req(input logic [31:0] ins, input logic [63:0] rs1,
                            input logic [63:0] rs2, input bit exp_resp,
                            input int lat, output int acc);
        logic [63:0] evl;
        logic [8:0]  evt;
        int n;
        exp_t e;
        n = 0;
        req_valid = 1;
        req_instr = ins;
        req_rs1   = rs1;
        req_rs2   = rs2;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept: got no req_ready within 200 cycles, required acceptance");
            req_valid = 0;
            acc = -1;
            return;
        end
        acc = cyc;
        if (exp_resp) begin
            model(ins, rs1, rs2, evl, evt);
            e.vl = evl;
            e.vt = evt;
            e.exp_cyc = (lat >= 0) ? acc + lat : -1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic pulse(input bit iss, input bit ret);
        issue  = iss;
        retire = ret;
        @(posedge clk);
        #1;
        issue  = 0;
        retire = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, hold_cyc, r_cyc, k;
        logic [31:0] ins;
        logic [63:0] rs1v, rs2v;
        logic [7:0]  vt8;

        repeat (3) @(posedge clk);
        #1 rst = 0;

        // First cycle after reset
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_vl", 64'(vl), 64'd0);
        check("rst_vtype", 64'(vtype), 64'h100);
        check("rst_vstart", 64'(vstart), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rd", resp_rd, 64'd0);
        check("rst_cnt", 64'(dut.cnt), 64'd0);
        @(posedge clk);
        #1;

        // vsetvli rd=x1 rs1=x5 (100), e32 m1
        send_req(mk_vsetvli(5'd1, 5'd5, 11'h010), 64'd100, 64'd0, 1, 3, acc);
        wait_idle();
        check("vsetvli_e32m1_vl", 64'(vl), 64'd100);

        // e8 m8 with rs1=x0 rd=x1 -> VLMAX, then rd=x0 rs1=x0 e16 m1 clamps
        send_req(mk_vsetvli(5'd1, 5'd0, 11'h003), 64'd0, 64'd0, 1, 3, acc);
        wait_idle();
        check("vlmax_e8m8_vl", 64'(vl), 64'd4096);
        send_req(mk_vsetvli(5'd0, 5'd0, 11'h008), 64'd0, 64'd0, 1, 3, acc);
        wait_idle();
        check("keep_clamp_vl", 64'(vl), 64'd256);

        // vsetivli uimm=31 e16 mf4, then e64 mf2 (illegal)
        send_req(mk_vsetivli(5'd2, 5'd31, 10'h00E), 64'd0, 64'd0, 1, 3, acc);
        wait_idle();
        check("vsetivli_mf4_vl", 64'(vl), 64'd31);
        send_req(mk_vsetivli(5'd2, 5'd31, 10'h01F), 64'd0, 64'd0, 1, 3, acc);
        wait_idle();
        check("vsetivli_ill_vl", 64'(vl), 64'd0);
        check("vsetivli_ill_vtype", 64'(vtype), 64'h100);

        // vsetvl with vsew=EW128 -> illegal
        send_req(mk_vsetvli(5'd1, 5'd5, 11'h010), 64'd77, 64'd0, 1, 3, acc);
        wait_idle();
        send_req(mk_vsetvl(5'd1, 5'd5, 5'd6), 64'd50, 64'h20, 1, 3, acc);
        wait_idle();
        check("vsetvl_ew128_vl", 64'(vl), 64'd0);
        check("vsetvl_ew128_vill", 64'(vtype.vill), 64'd1);
        check("vsetvl_vstart", 64'(vstart), 64'd0);

        // Drain: 3 in flight, request waits until the third retire
        for (int i = 0; i < 3; i++) pulse(1, 0);
        check("cnt_after_3_issue", 64'(dut.cnt), 64'd3);
        send_req(mk_vsetvli(5'd3, 5'd7, 11'h011), 64'd1000, 64'd0, 1, -1, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_issue_ready", 64'(issue_ready), 64'd0);
            check("drain_req_ready", 64'(req_ready), 64'd0);
            check("drain_resp_valid", 64'(resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        pulse(1, 0);
        check("drain_issue_ignored", 64'(dut.cnt), 64'd3);
        pulse(0, 1);
        pulse(0, 1);
        check("drain_cnt_1", 64'(dut.cnt), 64'd1);
        retire = 1;
        @(negedge clk);
        r_cyc = cyc;
        @(posedge clk);
        #1 retire = 0;
        check("drain_cnt_0", 64'(dut.cnt), 64'd0);
        @(negedge clk);
        check("drain_r1_valid", 64'(resp_valid), 64'd0);
        check("drain_r1_issue_ready", 64'(issue_ready), 64'd0);
        @(negedge clk);
        check("drain_r2_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("drain_r3_cycle", 64'(cyc), 64'(r_cyc + 3));
        check("drain_r3_valid", 64'(resp_valid), 64'd1);
        check("resp_issue_ready", 64'(issue_ready), 64'd1);
        @(posedge clk);
        wait_idle();

        // Counter corner cases
        pulse(1, 0);
        pulse(1, 1);
        check("cnt_issue_retire_same", 64'(dut.cnt), 64'd1);
        pulse(0, 1);
        pulse(0, 1);
        check("cnt_no_underflow", 64'(dut.cnt), 64'd0);
        for (int i = 0; i < int'(MAXO); i++) pulse(1, 0);
        check("cnt_full", 64'(dut.cnt), 64'(MAXO));
        check("full_issue_ready", 64'(issue_ready), 64'd0);
        pulse(1, 0);
        check("full_issue_ignored", 64'(dut.cnt), 64'(MAXO));
        for (int i = 0; i < int'(MAXO); i++) pulse(0, 1);
        check("cnt_empty", 64'(dut.cnt), 64'd0);

        // Request arriving during RESP waits for the return to IDLE
        resp_ready = 0;
        send_req(mk_vsetvli(5'd1, 5'd5, 11'h008), 64'd9, 64'd0, 1, 3, acc);
        hold_cyc = 0;
        fork
            send_req(mk_vsetvli(5'd1, 5'd6, 11'h010), 64'd12, 64'd0, 1, 3, acc_b);
            begin
                repeat (5) @(posedge clk);
                #1 resp_ready = 1;
                hold_cyc = cyc;
            end
        join
        check("resp_backpressure_accept", 64'(acc_b), 64'(hold_cyc + 1));
        wait_idle();
        check("resp_backpressure_vl", 64'(vl), 64'd12);

        // Reset while draining with two in flight
        pulse(1, 0);
        pulse(1, 0);
        send_req(mk_vsetvli(5'd1, 5'd5, 11'h010), 64'd33, 64'd0, 0, -1, acc);
        @(negedge clk);
        check("pre_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        model_vl = 0;
        @(negedge clk);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_issue_ready", 64'(issue_ready), 64'd1);
        check("mid_rst_cnt", 64'(dut.cnt), 64'd0);
        check("mid_rst_vl", 64'(vl), 64'd0);
        check("mid_rst_vill", 64'(vtype), 64'h100);
        repeat (10) @(negedge clk);
        check("mid_rst_no_resp", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with response backpressure and in-flight drains
        rr_rand = 1;
        for (int it = 0; it < 60; it++) begin
            wait_idle();
            k = $urandom_range(0, 3);
            if (k == 3) k = 0;
            for (int i = 0; i < k; i++) pulse(1, 0);
            vt8 = 8'($urandom);
            if ($urandom_range(0, 3) != 0) vt8[5] = 1'b0;
            case ($urandom_range(0, 3))
                0: rs1v = 64'($urandom_range(0, 300));
                1: rs1v = {32'($urandom), 32'($urandom)};
                2: rs1v = 64'($urandom_range(0, 5000));
                default: rs1v = 64'($urandom_range(0, 40));
            endcase
            rs2v = 64'(vt8);
            case ($urandom_range(0, 2))
                0: ins = mk_vsetvli(5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                                    {3'($urandom), vt8});
                1: ins = mk_vsetivli(5'($urandom_range(0, 2)), 5'($urandom),
                                     {2'($urandom), vt8});
                default: begin
                    if ($urandom_range(0, 7) == 0) rs2v[$urandom_range(8, 63)] = 1'b1;
                    ins = mk_vsetvl(5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                                    5'($urandom));
                end
            endcase
            fork
                send_req(ins, rs1v, rs2v, 1, (k == 0) ? 3 : -1, acc);
                begin
                    if (k > 0) begin
                        repeat ($urandom_range(1, 6)) @(posedge clk);
                        #1;
                        for (int i = 0; i < k; i++) pulse(0, 1);
                    end
                end
            join
        end
        wait_idle();
        rr_rand = 0;
        #2 resp_ready = 1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
